// File: rtl/pcm_i2s_tx_pkg.sv
// Shared audio definitions: default sample width, frame length helper and the
// LRCK slot polarity used by the clock generator, filter and this I2S sink.
package pcm_i2s_tx_pkg;

  localparam int unsigned I2S_W = 16;

  // Word-select levels on i2s_lrck.
  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  // One I2S frame carries both channels, so it is 2*w BCLK periods long.
  function automatic int unsigned frame_len(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/pcm_fifo.sv
// Synchronous first-word-fall-through FIFO for stereo PCM entries.
// Pointers carry one extra MSB so full and empty are distinguishable.
// DEPTH_LOG2 must be at least 1.
module pcm_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [Depth];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;

  // Occupancy flags derive only from registered pointers.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // A simultaneous pop frees the slot, so a push while full is still accepted.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/pcm_i2s_tx.sv
// I2S transmitter: buffers stereo PCM samples and serialises them MSB first
// with the standard one-BCLK delay after LRCK changes. All serial state moves
// on BCLK falling events derived from a clk divider.
module pcm_i2s_tx
  import pcm_i2s_tx_pkg::*;
#(
  parameter int unsigned W          = I2S_W,
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stb_in,
  input  logic [W-1:0]        din_left,
  input  logic [W-1:0]        din_right,
  output logic                full,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                underrun,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sd
);

  localparam int unsigned Frame = frame_len(W);
  localparam int unsigned CntW  = $clog2(Frame);
  localparam int unsigned DivW  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Frame - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(W);
  // Load one BCLK after LRCK falls so the MSB follows the I2S delay slot.
  localparam logic [CntW-1:0] CntLoad = CntW'(1);

  logic [DivW-1:0]  div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             lrck_q, lrck_d;
  logic             sd_q, sd_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [Frame-1:0] shreg_q, shreg_d;
  logic             overflow_q, overflow_d;
  logic             underrun_q, underrun_d;

  logic             tick, fall, pop;
  logic             fifo_empty;
  logic [Frame-1:0] fifo_dout;

  pcm_fifo #(
    .WIDTH      (Frame),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stb_in),
    .pop   (pop),
    .din   ({din_left, din_right}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty),
    .level (level)
  );

  // Divider, bit counter, frame load and shift; everything serial waits for a fall.
  always_comb begin
    div_d      = div_q;
    bclk_d     = bclk_q;
    lrck_d     = lrck_q;
    sd_d       = sd_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    underrun_d = 1'b0;
    pop        = 1'b0;

    tick = (div_q == DivLast);
    fall = tick && bclk_q;

    if (tick) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + 1'b1;
    end

    if (fall) begin
      bit_cnt_d = (bit_cnt_q == CntLast) ? '0 : bit_cnt_q + 1'b1;
      lrck_d    = (bit_cnt_d >= CntHalf) ? LRCK_RIGHT : LRCK_LEFT;
      if (bit_cnt_d == CntLoad) begin
        // The head MSB goes straight to SD; the rest waits in the shifter.
        if (!fifo_empty) begin
          pop     = 1'b1;
          sd_d    = fifo_dout[Frame-1];
          shreg_d = fifo_dout << 1;
        end else begin
          sd_d       = 1'b0;
          shreg_d    = '0;
          underrun_d = 1'b1;
        end
      end else begin
        sd_d    = shreg_q[Frame-1];
        shreg_d = shreg_q << 1;
      end
    end

    overflow_d = stb_in && full && !pop;
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sd_q       <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      sd_q       <= sd_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end

  assign i2s_bclk = bclk_q;
  assign i2s_lrck = lrck_q;
  assign i2s_sd   = sd_q;
  assign overflow = overflow_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Bench for pcm_i2s_tx: a queue-based model of the FIFO plus frame timing
// from plain arithmetic, and an I2S receiver that decodes words from LRCK/SD.
module tb_pcm_i2s_tx;

  localparam int W          = 16;
  localparam int BCLK_DIV   = 4;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 8;
  localparam int FRAME_CLK  = 2 * W * 2 * BCLK_DIV;  // 256 clk per stereo frame
  localparam int LOAD_PHASE = 2 * BCLK_DIV;          // first fall after frame start

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb_in = 1'b0;
  logic [15:0] din_left = '0;
  logic [15:0] din_right = '0;
  logic        full, overflow, underrun, i2s_bclk, i2s_lrck, i2s_sd;
  logic [3:0]  level;

  pcm_i2s_tx #(
    .W          (W),
    .BCLK_DIV   (BCLK_DIV),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stb_in    (stb_in),
    .din_left  (din_left),
    .din_right (din_right),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .underrun  (underrun),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_sd    (i2s_sd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int cmp_idx = 0;
  int frame_errs = 0;
  logic [31:0] mq[$];     // model FIFO contents
  logic [31:0] exp_w[$];  // expected word per frame (0 on underrun)
  logic [31:0] cap_w[$];  // words decoded from the serial pins
  logic m_ovf = 1'b0;
  logic m_und = 1'b0;

  // Receiver: a frame starts at the first BCLK rise with LRCK low after a
  // rise with LRCK high; the next 32 rises carry {L,R}, MSB first.
  logic mon_prev_bclk, mon_prev_lrck, mon_active;
  int   mon_cnt;
  logic [31:0] mon_word;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_bclk = 1'b0;
        mon_prev_lrck = 1'b1;
        mon_active    = 1'b0;
        mon_cnt       = 0;
        mon_word      = '0;
      end else begin
        if (i2s_bclk && !mon_prev_bclk) begin
          if (!i2s_lrck && mon_prev_lrck) begin
            if (mon_active) begin
              if (mon_cnt == 31) cap_w.push_back({mon_word[30:0], i2s_sd});
              else frame_errs++;
            end
            mon_active = 1'b1;
            mon_cnt    = 0;
            mon_word   = '0;
          end else if (mon_active) begin
            mon_word = {mon_word[30:0], i2s_sd};
            mon_cnt++;
          end
          mon_prev_lrck = i2s_lrck;
        end
        mon_prev_bclk = i2s_bclk;
      end
    end
  end

  // One clk of stimulus plus the model update for that edge.
  task automatic tick(input logic stb, input logic [15:0] l, input logic [15:0] r);
    logic load;
    stb_in = stb;
    din_left = l;
    din_right = r;
    @(posedge clk);
    edge_n++;
    load  = (edge_n % FRAME_CLK) == LOAD_PHASE;
    m_und = load && (mq.size() == 0);
    m_ovf = stb && (mq.size() == DEPTH) && !(load && mq.size() > 0);
    if (load) exp_w.push_back((mq.size() > 0) ? mq.pop_front() : 32'h0);
    if (stb && !m_ovf) mq.push_back({l, r});
    #1;
    stb_in = 1'b0;
  endtask

  task automatic restart_model();
    edge_n = 0;
    mq.delete();
    exp_w.delete();
    cap_w.delete();
    cmp_idx = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({full, level, overflow, underrun} !== 7'b0) begin
      errors++;
      $display("FAIL reset status: got %b want 0", {full, level, overflow, underrun});
    end
    checks++;
    if ({i2s_bclk, i2s_lrck, i2s_sd} !== 3'b0) begin
      errors++;
      $display("FAIL reset i2s: got %b want 000", {i2s_bclk, i2s_lrck, i2s_sd});
    end
    @(negedge clk);
    rst = 1'b0;
    restart_model();
  endtask

  task automatic test_idle();
    logic [6:0] want;
    int und_cnt = 0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      tick(1'b0, 16'h0, 16'h0);
      if (underrun) und_cnt++;
      checks++;
      if (i2s_bclk !== 1'((edge_n / BCLK_DIV) % 2)) begin
        errors++;
        $display("FAIL idle bclk @%0d: got %b want %0d", edge_n, i2s_bclk, (edge_n / BCLK_DIV) % 2);
      end
      checks++;
      if (i2s_lrck !== ((edge_n % FRAME_CLK) >= FRAME_CLK / 2)) begin
        errors++;
        $display("FAIL idle lrck @%0d: got %b", edge_n, i2s_lrck);
      end
      checks++;
      if (i2s_sd !== 1'b0) begin
        errors++;
        $display("FAIL idle sd @%0d: got %b want 0", edge_n, i2s_sd);
      end
      want = {mq.size() == DEPTH, 4'(mq.size()), m_ovf, m_und};
      checks++;
      if ({full, level, overflow, underrun} !== want) begin
        errors++;
        $display("FAIL idle status @%0d: got %b want %b", edge_n, {full, level, overflow, underrun}, want);
      end
    end
    checks++;
    if (und_cnt != 2) begin
      errors++;
      $display("FAIL idle underrun count: got %0d want 2", und_cnt);
    end
  endtask

  task automatic test_single(input string name, input logic [15:0] l, input logic [15:0] r);
    logic [6:0] want;
    logic seen = 1'b0;
    tick(1'b1, l, r);
    checks++;
    if (level !== 4'd1) begin
      errors++;
      $display("FAIL %s level after push: got %0d want 1", name, level);
    end
    for (int i = 0; i < 4 * FRAME_CLK; i++) begin
      if (mq.size() == 0 && cap_w.size() == exp_w.size()) break;
      tick(1'b0, 16'h0, 16'h0);
      want = {mq.size() == DEPTH, 4'(mq.size()), m_ovf, m_und};
      checks++;
      if ({full, level, overflow, underrun} !== want) begin
        errors++;
        $display("FAIL %s status @%0d: got %b want %b", name, edge_n, {full, level, overflow, underrun}, want);
      end
    end
    checks++;
    if (!(mq.size() == 0 && cap_w.size() == exp_w.size())) begin
      errors++;
      $display("FAIL %s drain timeout: captured %0d want %0d words", name, cap_w.size(), exp_w.size());
    end
    for (int i = cmp_idx; i < cap_w.size(); i++) begin
      checks++;
      if (cap_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL %s word[%0d]: got %h want %h", name, i, cap_w[i], exp_w[i]);
      end
      if (cap_w[i] === {l, r}) seen = 1'b1;
    end
    cmp_idx = cap_w.size();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s serial word: %h not found on sd", name, {l, r});
    end
  endtask

  task automatic test_back_to_back(input logic push_on_pop);
    logic [6:0] want;
    while ((edge_n % FRAME_CLK) != LOAD_PHASE + 2) tick(1'b0, 16'h0, 16'h0);
    for (int n = 1; n <= (push_on_pop ? 8 : 9); n++) begin
      tick(1'b1, 16'($urandom), 16'($urandom));
      if (n == 8) begin
        checks++;
        if (full !== 1'b1 || level !== 4'd8) begin
          errors++;
          $display("FAIL fill 8th push: got full=%b level=%0d want 1/8", full, level);
        end
      end
      if (n == 9) begin
        checks++;
        if (overflow !== 1'b1 || level !== 4'd8) begin
          errors++;
          $display("FAIL overflow 9th push: got ovf=%b level=%0d want 1/8", overflow, level);
        end
      end
    end
    if (push_on_pop) begin
      while (((edge_n + 1) % FRAME_CLK) != LOAD_PHASE) tick(1'b0, 16'h0, 16'h0);
      tick(1'b1, 16'h1234, 16'h5678);
      checks++;
      if (overflow !== 1'b0 || level !== 4'd8 || full !== 1'b1) begin
        errors++;
        $display("FAIL push_on_pop: got ovf=%b level=%0d full=%b want 0/8/1", overflow, level, full);
      end
    end
    for (int i = 0; i < 14 * FRAME_CLK; i++) begin
      if (mq.size() == 0 && cap_w.size() == exp_w.size()) break;
      tick(1'b0, 16'h0, 16'h0);
      want = {mq.size() == DEPTH, 4'(mq.size()), m_ovf, m_und};
      checks++;
      if ({full, level, overflow, underrun} !== want) begin
        errors++;
        $display("FAIL b2b status @%0d: got %b want %b", edge_n, {full, level, overflow, underrun}, want);
      end
    end
    checks++;
    if (!(mq.size() == 0 && cap_w.size() == exp_w.size())) begin
      errors++;
      $display("FAIL b2b drain timeout: captured %0d want %0d words", cap_w.size(), exp_w.size());
    end
    for (int i = cmp_idx; i < cap_w.size(); i++) begin
      checks++;
      if (cap_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL b2b word[%0d]: got %h want %h", i, cap_w[i], exp_w[i]);
      end
    end
    cmp_idx = cap_w.size();
  endtask

  task automatic test_reset_mid();
    logic [6:0] want;
    while ((edge_n % FRAME_CLK) != 2) tick(1'b0, 16'h0, 16'h0);
    tick(1'b1, 16'hDEAD, 16'hBEEF);
    tick(1'b1, 16'hCAFE, 16'hF00D);
    // bit_cnt reaches 7 at the seventh fall of the frame
    while ((edge_n % FRAME_CLK) != 7 * 2 * BCLK_DIV + 2) tick(1'b0, 16'h0, 16'h0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({full, level, overflow, underrun, i2s_bclk, i2s_lrck, i2s_sd} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid async: got %b want 0",
               {full, level, overflow, underrun, i2s_bclk, i2s_lrck, i2s_sd});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    restart_model();
    for (int i = 0; i < FRAME_CLK + 16; i++) begin
      tick(1'b0, 16'h0, 16'h0);
      checks++;
      if (i2s_bclk !== 1'((edge_n / BCLK_DIV) % 2) ||
          i2s_lrck !== ((edge_n % FRAME_CLK) >= FRAME_CLK / 2)) begin
        errors++;
        $display("FAIL reset_mid restart @%0d: got bclk=%b lrck=%b", edge_n, i2s_bclk, i2s_lrck);
      end
      want = {mq.size() == DEPTH, 4'(mq.size()), m_ovf, m_und};
      checks++;
      if ({full, level, overflow, underrun} !== want) begin
        errors++;
        $display("FAIL reset_mid status @%0d: got %b want %b", edge_n, {full, level, overflow, underrun}, want);
      end
    end
    checks++;
    if (cap_w.size() < 1 || cap_w[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid first frame: got %0d words, want one silent word", cap_w.size());
    end
    cmp_idx = cap_w.size();
  endtask

  task automatic test_random();
    logic [6:0] want;
    logic       stb;
    for (int i = 0; i < 3000; i++) begin
      stb = ($urandom_range(0, 39) == 0);
      tick(stb, 16'($urandom), 16'($urandom));
      want = {mq.size() == DEPTH, 4'(mq.size()), m_ovf, m_und};
      checks++;
      if ({full, level, overflow, underrun} !== want) begin
        errors++;
        $display("FAIL random status @%0d: got %b want %b", edge_n, {full, level, overflow, underrun}, want);
      end
    end
    for (int i = 0; i < 14 * FRAME_CLK; i++) begin
      if (mq.size() == 0 && cap_w.size() == exp_w.size()) break;
      tick(1'b0, 16'h0, 16'h0);
      want = {mq.size() == DEPTH, 4'(mq.size()), m_ovf, m_und};
      checks++;
      if ({full, level, overflow, underrun} !== want) begin
        errors++;
        $display("FAIL random drain status @%0d: got %b want %b", edge_n, {full, level, overflow, underrun}, want);
      end
    end
    checks++;
    if (!(mq.size() == 0 && cap_w.size() == exp_w.size())) begin
      errors++;
      $display("FAIL random drain timeout: captured %0d want %0d words", cap_w.size(), exp_w.size());
    end
    for (int i = cmp_idx; i < cap_w.size(); i++) begin
      checks++;
      if (cap_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL random word[%0d]: got %h want %h", i, cap_w[i], exp_w[i]);
      end
    end
    cmp_idx = cap_w.size();
    checks++;
    if (frame_errs != 0) begin
      errors++;
      $display("FAIL framing: got %0d short frames want 0", frame_errs);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single("single", 16'hA5C3, 16'h0F01);
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_single("sign", 16'h8000, 16'h7FFF);
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
